// File: rtl/reg_monitor_scan_pkg.sv
// ----------------------------------------------------------------------------
// reg_monitor_scan_pkg
// Shared definitions for the register-monitor scan block:
//   - scan FSM state encoding (IDLE/LOAD/SEND/FIN)
//   - frame geometry (5 bytes per register: index header + 4 data bytes)
//   - helper that builds the index-byte header of a frame
// No ports (package).
// ----------------------------------------------------------------------------
package reg_monitor_scan_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int FRAME_BYTES = 5;
    localparam int FRAME_W     = FRAME_BYTES * 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        FIN  = 2'd3
    } scanState_t;

    // Header byte of every frame: three zero bits above the 5-bit register index.
    function automatic logic [7:0] frameHeader(input logic [REG_IDX_W-1:0] idx);
        return {3'b000, idx};
    endfunction

endpackage

// File: rtl/reg_monitor_scan_if.sv
// ----------------------------------------------------------------------------
// reg_monitor_scan_if
// Bundles the control handshake (start/busy/done), the register-file debug
// read port (dbg_ra -> dbg_rd) and the outgoing valid/ready byte stream.
//   master : the scan block (drives busy, done, dbg_ra, tx_data, tx_valid)
//   slave  : the environment (drives start, dbg_rd, tx_ready)
// ----------------------------------------------------------------------------
interface reg_monitor_scan_if;
    import reg_monitor_scan_pkg::*;

    logic                 start;
    logic                 busy;
    logic                 done;
    logic [REG_IDX_W-1:0] dbg_ra;
    logic [31:0]          dbg_rd;
    logic [7:0]           tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        input  start, dbg_rd, tx_ready,
        output busy, done, dbg_ra, tx_data, tx_valid
    );

    modport slave (
        output start, dbg_rd, tx_ready,
        input  busy, done, dbg_ra, tx_data, tx_valid
    );

endinterface

// File: rtl/reg_monitor_scan_tx_frame_ser.sv
// ----------------------------------------------------------------------------
// tx_frame_ser
// Holds one 40-bit register frame and streams it out MSB byte first over a
// valid/ready interface.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   load         1-cycle strobe: capture frameIn and start presenting byte 0
//   frameIn      {header, data[31:0]} to send
//   tx_data      current byte (top byte of the shift register)
//   tx_valid     byte is valid; registered, never a function of tx_ready
//   tx_ready     sink accepts on tx_valid & tx_ready at posedge
//   frameDone    combinational pulse in the cycle the last byte is accepted
// ----------------------------------------------------------------------------
module tx_frame_ser
    import reg_monitor_scan_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] frameIn,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic               frameDone
);

    localparam logic [2:0] LAST_BYTE = 3'(FRAME_BYTES - 1);

    logic [FRAME_W-1:0] frameReg;
    logic [2:0]         byteCnt;
    logic               accept;

    // Bytes leave from the top of the register; shifting in zeros means tx_data
    // falls back to 0 once the frame has drained.
    assign accept    = tx_valid & tx_ready;
    assign frameDone = accept && (byteCnt == LAST_BYTE);
    assign tx_data   = frameReg[FRAME_W-1 -: 8];

    // Frame capture and byte advance. The data only moves on an accepted byte,
    // so a stalled byte stays stable, and tx_valid stays high across the frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frameReg <= '0;
            byteCnt  <= '0;
            tx_valid <= 1'b0;
        end else if (load) begin
            frameReg <= frameIn;
            byteCnt  <= '0;
            tx_valid <= 1'b1;
        end else if (accept) begin
            frameReg <= {frameReg[FRAME_W-9:0], 8'h00};
            if (byteCnt == LAST_BYTE) begin
                byteCnt  <= '0;
                tx_valid <= 1'b0;
            end else begin
                byteCnt <= byteCnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/reg_monitor_scan.sv
// ----------------------------------------------------------------------------
// reg_monitor_scan
// Debug-port consumer for the monitor block. A start pulse sweeps register
// indices FIRST_REG..LAST_REG, snapshots each value through the debug read
// port and emits it as a 5-byte frame {idx, rd[31:24], rd[23:16], rd[15:8],
// rd[7:0]} on a valid/ready byte stream toward the monitor UART. Read-only
// with respect to CPU state.
// Parameters:
//   FIRST_REG   first index swept (0..31)
//   LAST_REG    last index swept (FIRST_REG..31)
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   mon         reg_monitor_scan_if.master: start/busy/done, dbg_ra/dbg_rd,
//               tx_data/tx_valid/tx_ready
// ----------------------------------------------------------------------------
module reg_monitor_scan
    import reg_monitor_scan_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
)
(
    input logic               clk,
    input logic               reset,
    reg_monitor_scan_if.master mon
);

    localparam logic [REG_IDX_W-1:0] FIRST_IDX = REG_IDX_W'(FIRST_REG);
    localparam logic [REG_IDX_W-1:0] LAST_IDX  = REG_IDX_W'(LAST_REG);

    scanState_t           state, nextState;
    logic                 busyReg, busyNext;
    logic                 doneReg, doneNext;
    logic [REG_IDX_W-1:0] raReg, raNext;
    logic                 loadFrame;
    logic                 frameDone;
    logic [FRAME_W-1:0]   frameIn;
    logic [7:0]           serData;
    logic                 serValid;

    // The frame is snapshotted in LOAD, when dbg_ra has been stable for a cycle
    // and dbg_rd therefore reflects the addressed register.
    assign frameIn = {frameHeader(raReg), mon.dbg_rd};

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and next-output logic. A start is only honoured in IDLE and not
    // while the previous sweep's done pulse is still showing, so nothing queues.
    // The index test happens before incrementing, so LAST_REG=31 never wraps.
    always_comb begin
        nextState = state;
        busyNext  = busyReg;
        doneNext  = 1'b0;
        raNext    = raReg;
        loadFrame = 1'b0;
        case (state)
            IDLE: begin
                if (mon.start && !doneReg) begin
                    nextState = LOAD;
                    raNext    = FIRST_IDX;
                    busyNext  = 1'b1;
                end
            end
            LOAD: begin
                loadFrame = 1'b1;
                nextState = SEND;
            end
            SEND: begin
                if (frameDone) begin
                    if (raReg == LAST_IDX) begin
                        nextState = FIN;
                    end else begin
                        raNext    = raReg + 5'd1;
                        nextState = LOAD;
                    end
                end
            end
            FIN: begin
                doneNext  = 1'b1;
                busyNext  = 1'b0;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Registered control outputs. dbg_ra, busy and done are all flops so the
    // register file sees a glitch-free address.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            raReg   <= '0;
        end else begin
            busyReg <= busyNext;
            doneReg <= doneNext;
            raReg   <= raNext;
        end
    end

    tx_frame_ser u_ser (
        .clk       (clk),
        .reset     (reset),
        .load      (loadFrame),
        .frameIn   (frameIn),
        .tx_data   (serData),
        .tx_valid  (serValid),
        .tx_ready  (mon.tx_ready),
        .frameDone (frameDone)
    );

    assign mon.busy     = busyReg;
    assign mon.done     = doneReg;
    assign mon.dbg_ra   = raReg;
    assign mon.tx_data  = serData;
    assign mon.tx_valid = serValid;

endmodule
